// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave: byte-lane writes, configurable wait states,
// two-cycle ERROR response and same-word write-to-read forwarding.
module ahb_lite_sram_slave #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned LANE_W    = $clog2(BYTES);
  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);
  localparam logic [2:0]  WS        = 3'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                r_state;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [2:0]            r_wcnt;
  logic                  r_write;
  logic [IDX_W-1:0]      r_idx;
  logic [LANE_W-1:0]     r_lane;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_range;
  logic                  w_size_ok;
  logic [2:0]            w_align_mask;
  logic                  w_aligned;
  logic                  w_legal;
  logic                  w_accept;
  logic [IDX_W-1:0]      w_idx;
  logic [LANE_W-1:0]     w_lane;
  logic [BYTES-1:0]      w_be;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  // Address-phase decode and legality
  assign w_off        = HADDR - BASE_ADDR;
  assign w_in_range   = (HADDR >= BASE_ADDR) && (64'(w_off) < MEM_BYTES);
  assign w_size_ok    = (HSIZE <= 3'(LANE_W));
  assign w_align_mask = 3'((4'd1 << HSIZE[1:0]) - 4'd1);
  assign w_aligned    = ((HADDR[2:0] & w_align_mask) == 3'd0);
  assign w_legal      = w_in_range && w_size_ok && w_aligned;
  assign w_accept     = HSEL && HREADY && HTRANS[1];
  assign w_idx        = w_off[LANE_W +: IDX_W];
  assign w_lane       = HADDR[LANE_W-1:0];
  assign w_unused     = ^{HBURST, HPROT, HTRANS[0]};

  // Byte enables of the registered transfer
  always_comb begin
    w_be = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if ((b >= 32'(r_lane)) && (b < 32'(r_lane) + (32'd1 << r_size))) begin
        w_be[b] = 1'b1;
      end
    end
  end

  assign w_commit = (r_state == S_DATA) && r_write && !HRESET;

  // Word as it will look after the in-flight write commits (forwarding source)
  always_comb begin
    w_merged = r_mem[r_idx];
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (w_be[b]) begin
        w_merged[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  assign w_rd_word = (w_commit && (w_idx == r_idx)) ? w_merged : r_mem[w_idx];

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Transfer FSM with registered bus responses
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_wcnt      <= '0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_lane      <= '0;
      r_size      <= '0;
    end else begin
      r_hrdata <= '0;
      case (r_state)
        S_WAIT: begin
          if (r_wcnt == 3'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
            if (!r_write) begin
              r_hrdata <= r_mem[r_idx];
            end
          end else begin
            r_wcnt <= r_wcnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_lane  <= w_lane;
            r_size  <= HSIZE;
            r_write <= HWRITE;
            if (!w_legal) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WS != 3'd0) begin
              r_state     <= S_WAIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
              r_wcnt      <= WS - 3'd1;
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
              if (!HWRITE) begin
                r_hrdata <= w_rd_word;
              end
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: directed and random transfers on a zero-wait
// and a three-wait instance, checked against a byte-addressed memory model.
module tb_ahb_lite_sram_slave;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    bit          chk;
    logic [31:0] cval;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        ro0, ro3, rs0, rs3;
  logic [31:0] rd0, rd3;

  int  checks = 0;
  int  errors = 0;
  op_t ops[$];
  byte unsigned mem_m [2][4096];

  always #5 clk = ~clk;

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024),
                        .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HWDATA(hwdata), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024),
                        .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HWDATA(hwdata), .HREADY(ro3), .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(bit w, logic [31:0] a, logic [2:0] s, logic [31:0] dt,
                             bit c = 1'b0, logic [31:0] cv = 32'h0);
    op_t o;
    o.write = w; o.addr = a; o.size = s; o.data = dt; o.chk = c; o.cval = cv;
    return o;
  endfunction

  function automatic bit is_legal(op_t o);
    return (o.addr < 32'd4096) && (o.size <= 3'd2) && ((o.addr % (32'd1 << o.size)) == 0);
  endfunction

  function automatic logic [31:0] model_word(int d, logic [31:0] a);
    int unsigned b;
    b = a & ~32'd3;
    return {mem_m[d][b+3], mem_m[d][b+2], mem_m[d][b+1], mem_m[d][b]};
  endfunction

  task automatic model_write(int d, op_t o);
    int unsigned a;
    for (int k = 0; k < (1 << o.size); k++) begin
      a = o.addr + 32'(k);
      mem_m[d][a] = o.data[8*(a%4) +: 8];
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    int  kind;
    o.write = $urandom_range(0, 1) == 1;
    o.data  = $urandom;
    o.chk   = 1'b0;
    o.cval  = 32'h0;
    kind    = $urandom_range(0, 9);
    if (kind == 0) begin
      o.size = 3'd2; o.addr = 32'h1000 + 4 * $urandom_range(0, 255);
    end else if (kind == 1) begin
      o.size = 3'd3; o.addr = 8 * $urandom_range(0, 31);
    end else if (kind == 2) begin
      o.size = 3'(1 + $urandom_range(0, 1)); o.addr = 4 * $urandom_range(0, 63) + 1;
    end else begin
      o.size = 3'($urandom_range(0, 2));
      o.addr = 32'($urandom_range(0, 255)) & ~((32'd1 << o.size) - 32'd1);
    end
    return o;
  endfunction

  // Issue the queued transfers back-to-back on one slave and check every data phase
  task automatic run(input int d);
    int          i = 0;
    int          lows = 0;
    bit          have_d = 1'b0;
    bit          stop = 1'b0;
    bit          legal;
    op_t         cur;
    logic        rdy, rsp;
    logic [31:0] rd;
    int          ws;
    ws = (d == 0) ? 0 : 3;
    hsel0 = (d == 0);
    hsel3 = (d == 1);
    while (!stop && (i < ops.size() || have_d)) begin
      rdy = (d == 0) ? ro0 : ro3;
      rsp = (d == 0) ? rs0 : rs3;
      rd  = (d == 0) ? rd0 : rd3;
      if (have_d && !rdy) begin
        lows++;
        chk("wait_hresp", 32'(rsp), 32'(!is_legal(cur)));
        if (lows > 16) begin
          errors++;
          $error("FAIL hreadyout_stuck got=%0d low cycles exp<=%0d", lows, 16);
          stop = 1'b1;
        end else begin
          tick();
        end
      end else begin
        if (have_d) begin
          legal = is_legal(cur);
          chk("wait_cycles", 32'(lows), legal ? 32'(ws) : 32'd1);
          chk("hresp", 32'(rsp), 32'(!legal));
          if (!cur.write) begin
            chk("hrdata", rd, legal ? model_word(d, cur.addr) : 32'h0);
            if (cur.chk) chk("hrdata_const", rd, cur.cval);
          end
          if (cur.write && legal) model_write(d, cur);
          have_d = 1'b0;
          lows   = 0;
        end
        if (i < ops.size()) begin
          cur    = ops[i];
          i++;
          haddr  = cur.addr;
          hwrite = cur.write;
          hsize  = cur.size;
          htrans = 2'd2;
          have_d = 1'b1;
        end else begin
          htrans = 2'd0;
        end
        tick();
        if (have_d && cur.write) hwdata = cur.data;
      end
    end
    htrans = 2'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; htrans = 2'd0; hwdata = '0;
    tick();
    tick();
    chk("rst_ready0", 32'(ro0), 32'd1);
    chk("rst_resp0",  32'(rs0), 32'd0);
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_ready3", 32'(ro3), 32'd1);
    chk("rst_resp3",  32'(rs3), 32'd0);
    chk("rst_rdata3", rd3, 32'h0);
    rst = 1'b0;
    tick();

    for (int d = 0; d < 2; d++) begin
      ops.delete();
      for (int w = 0; w < 64; w++) ops.push_back(mk(1'b1, 32'(4 * w), 3'd2, $urandom));
      run(d);
    end

    ops.delete();
    ops.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
    ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF));
    ops.push_back(mk(1'b1, 32'h10, 3'd2, 32'h11223344));
    ops.push_back(mk(1'b1, 32'h13, 3'd0, 32'hAA000000));
    ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hAA223344));
    ops.push_back(mk(1'b1, 32'h20, 3'd2, 32'h12345678));
    ops.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0, 1'b1, 32'h12345678));
    ops.push_back(mk(1'b1, 32'h00, 3'd2, 32'hCAFEF00D));
    ops.push_back(mk(1'b0, 32'h1000, 3'd2, 32'h0));
    ops.push_back(mk(1'b1, 32'h01, 3'd1, 32'hFFFFFFFF));
    ops.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0, 1'b1, 32'hCAFEF00D));
    run(0);

    ops.delete();
    ops.push_back(mk(1'b1, 32'h30, 3'd2, 32'h0BADF00D));
    ops.push_back(mk(1'b0, 32'h30, 3'd2, 32'h0, 1'b1, 32'h0BADF00D));
    run(1);

    // Reset in the middle of a waited write must drop the write
    hsel3 = 1'b1; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
    tick();
    hwdata = 32'h55555555; htrans = 2'd0;
    chk("wait_ready_low", 32'(ro3), 32'd0);
    rst = 1'b1;
    tick();
    chk("abort_ready", 32'(ro3), 32'd1);
    chk("abort_resp",  32'(rs3), 32'd0);
    chk("abort_rdata", rd3, 32'h0);
    rst = 1'b0;
    hsel3 = 1'b0;
    tick();
    ops.delete();
    ops.push_back(mk(1'b0, 32'h30, 3'd2, 32'h0, 1'b1, 32'h0BADF00D));
    run(1);

    for (int d = 0; d < 2; d++) begin
      ops.delete();
      for (int n = 0; n < 80; n++) ops.push_back(rand_op());
      run(d);
    end

    hsel0 = 1'b0; hsel3 = 1'b0;
    tick();
    chk("end_ready0", 32'(ro0), 32'd1);
    chk("end_resp0",  32'(rs0), 32'd0);
    chk("end_ready3", 32'(ro3), 32'd1);
    chk("end_resp3",  32'(rs3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
